// File: rtl/divu_iter_pkg.sv
// Shared widths, divider state encodings and iteration count for the HI/LO datapath.
package divu_iter_pkg;

    localparam int REG_BUS  = 32;
    localparam int DREG_BUS = 64;
    localparam int DIV_ITER = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/divu_iter_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module divu_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Partial remainder is always < divisor, so its top bit is zero and the
    // shift fits in WIDTH+1 bits; trial bit WIDTH is the borrow.
    always_comb begin
        shifted = {rem_in[WIDTH-1:0], next_bit};
        trial   = shifted - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            rem_out = trial;
            q_bit   = 1'b1;
        end else begin
            rem_out = shifted;
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/divu_iter.sv
// Iterative unsigned divider: one quotient bit per clock, start/busy/done handshake.
module divu_iter
    import divu_iter_pkg::*;
#(
    parameter int WIDTH = DIV_ITER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd_sr;   // dividend bits shift out the top, quotient bits shift in the bottom
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH:0]   prem;
    logic [WIDTH:0]   prem_nxt;
    logic             q_bit;
    logic             last_step;

    divu_iter_step #(.WIDTH(WIDTH)) u_step (
        .rem_in   (prem),
        .next_bit (dvd_sr[WIDTH-1]),
        .divisor  (dvs_r),
        .rem_out  (prem_nxt),
        .q_bit    (q_bit)
    );

    assign last_step = (cnt == CNT_W'(WIDTH - 1));
    assign busy      = (state == DIV_RUN);
    assign done      = (state == DIV_DONE);

    // Next-state: accept only in IDLE, run WIDTH steps, single DONE cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (start) state_nxt = DIV_RUN;
            DIV_RUN:  if (last_step) state_nxt = DIV_DONE;
            DIV_DONE: state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= DIV_IDLE;
        else        state <= state_nxt;
    end

    // Datapath: latch operands on accept, iterate in RUN, publish on the last step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            dvd_sr    <= '0;
            dvs_r     <= '0;
            prem      <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        dvd_sr <= dividend;
                        dvs_r  <= divisor;
                        prem   <= '0;
                        cnt    <= '0;
                    end
                end
                DIV_RUN: begin
                    dvd_sr <= {dvd_sr[WIDTH-2:0], q_bit};
                    prem   <= prem_nxt;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_step) begin
                        quotient  <= {dvd_sr[WIDTH-2:0], q_bit};
                        remainder <= prem_nxt[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divu_iter.sv
// Directed bench for divu_iter with a result scoreboard.
module tb_divu_iter;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done;
    logic [W-1:0] quotient, remainder;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    divu_iter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.q = '1;
            e.r = a;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Issue one op at a negedge in IDLE, follow it to its done pulse, score the result.
    // With poke set, a second start with different operands is pulsed mid-run.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
        int   cyc = 0;
        int   overlap = 0;
        int   held_bad = 0;
        int   stray = 0;
        exp_t e;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back(model(a, b));
        @(negedge clk);
        start = 1'b0;
        while (busy === 1'b1 && cyc < 100) begin
            if (done !== 1'b0) overlap++;
            if (quotient !== last_q || remainder !== last_r) held_bad++;
            cyc++;
            if (poke && cyc == 5) begin
                start    = 1'b1;
                dividend = 32'd7;
                divisor  = 32'd3;
            end else begin
                start = 1'b0;
                if (poke && cyc > 5) begin
                    dividend = 32'd55;
                    divisor  = 32'd11;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_cycles", W'(cyc), W'(32));
        chk("busy_done_overlap", W'(overlap), '0);
        chk("outputs_held_in_run", W'(held_bad), '0);
        chk("done_pulse", W'(done), W'(1));
        chk("sb_nonempty", W'(sb.size() != 0), W'(1));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            last_q = e.q;
            last_r = e.r;
        end
        @(negedge clk);
        chk("done_one_cycle", W'(done), '0);
        if (poke) begin
            for (int i = 0; i < 40; i++) begin
                if (done !== 1'b0 || busy !== 1'b0) stray++;
                @(negedge clk);
            end
            chk("no_second_op", W'(stray), '0);
            chk("sb_empty", W'(sb.size()), '0);
        end
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_quotient", quotient, '0);
        chk("rst_remainder", remainder, '0);
        reset = 1'b1;
        @(negedge clk);

        run_op(32'd100, 32'd7, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h0001_0000, 1'b0);
        run_op(32'h1234_5678, 32'd0, 1'b0);
        run_op(32'd5, 32'd9, 1'b0);
        run_op(32'd1000, 32'd10, 1'b1);

        // back-to-back: second start at the first legal edge after done
        run_op(32'd1000, 32'd10, 1'b0);
        run_op(32'd81, 32'd9, 1'b0);

        // reset mid-run discards the op
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        chk("pre_reset_busy", W'(busy), W'(1));
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", W'(busy), '0);
        chk("mid_rst_done", W'(done), '0);
        chk("mid_rst_quotient", quotient, '0);
        chk("mid_rst_remainder", remainder, '0);
        last_q = '0;
        last_r = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", W'(busy | done), '0);
        run_op(32'd1000, 32'd10, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
